program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/rv_pkg.sv | 8 +
 rtl/program_counter.sv | 44 ++++
 tb/tb_program_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the RV fetch path: the default reset vector and the
// instruction alignment step used by the next-sequential-PC adder.
package rv_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES          = 4;

endpackage : rv_pkg

// File: rtl/program_counter.sv
// Program counter register with a combinational PC+4 adder and registered
// misalignment and valid flags; it loads PCNext on every clock edge out of reset.
module program_counter
  import rv_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCNext,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             PCMisaligned,
  output logic             PCValid
);

  logic [WIDTH-1:0] r_pc;
  logic             r_misaligned;
  logic             r_valid;
  logic             w_next_misaligned;

  // The flag is computed from PCNext so that it always describes the PC that
  // is presented after the same edge.
  assign w_next_misaligned = |PCNext[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_VECTOR;
      r_misaligned <= |RESET_VECTOR[1:0];
      r_valid      <= 1'b0;
    end else begin
      r_pc         <= PCNext;
      r_misaligned <= w_next_misaligned;
      r_valid      <= 1'b1;
    end
  end

  assign PC           = r_pc;
  assign PCPlus4      = r_pc + WIDTH'(INSTR_BYTES);
  assign PCMisaligned = r_misaligned;
  assign PCValid      = r_valid;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed and randomized bench for program_counter, with a behavioural
// reference model that tracks the expected PC.
module tb_program_counter;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [31:0] PCNext = 32'h0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCMisaligned;
  logic        PCValid;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc    = 32'h0;
  logic        m_valid = 1'b0;

  program_counter #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .PCNext       (PCNext),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .PCMisaligned (PCMisaligned),
    .PCValid      (PCValid)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] plus4;
    plus4 = m_pc + 32'd4;
    chk32({tag, "_pc"}, PC, m_pc);
    chk32({tag, "_plus4"}, PCPlus4, plus4);
    chk1({tag, "_mis"}, PCMisaligned, (m_pc % 4) != 0);
    chk1({tag, "_valid"}, PCValid, m_valid);
  endtask

  // Drive a new next-PC value away from the edge, clock it, and update the model.
  task automatic apply(input logic [31:0] nxt);
    @(negedge clk);
    PCNext = nxt;
    @(posedge clk);
    #1;
    if (reset) begin
      m_pc    = nxt;
      m_valid = 1'b1;
    end else begin
      m_pc    = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] v;

    // Power-up: held in reset across the first edge
    #10;
    chk32("pwr_pc", PC, 32'h0000_0000);
    chk1("pwr_valid", PCValid, 1'b0);
    chk32("pwr_plus4", PCPlus4, 32'h0000_0004);
    chk1("pwr_mis", PCMisaligned, 1'b0);

    // Release away from a clock edge
    #2;
    reset = 1'b1;
    apply(32'h0);
    chk32("rel_pc", PC, 32'h0000_0000);
    chk1("rel_valid", PCValid, 1'b1);
    chk1("rel_mis", PCMisaligned, 1'b0);

    apply(32'd12345678);
    chk32("seq0_pc", PC, 32'h00BC_614E);
    chk1("seq0_mis", PCMisaligned, 1'b1);
    apply(32'd17291729);
    chk32("seq1_pc", PC, 32'h0107_D9D1);
    chk1("seq1_mis", PCMisaligned, 1'b1);
    apply(32'd87654321);
    chk32("seq2_pc", PC, 32'h0539_7FB1);
    chk1("seq2_mis", PCMisaligned, 1'b1);

    apply(32'h0000_0100);
    chk32("algn_pc", PC, 32'h0000_0100);
    chk32("algn_plus4", PCPlus4, 32'h0000_0104);
    chk1("algn_mis", PCMisaligned, 1'b0);

    apply(32'hFFFF_FFFC);
    chk32("wrap_pc", PC, 32'hFFFF_FFFC);
    chk32("wrap_plus4", PCPlus4, 32'h0000_0000);

    // PC must hold while PCNext moves between edges
    @(negedge clk);
    PCNext = 32'h1234_5670;
    #2;
    chk32("hold_pc", PC, 32'hFFFF_FFFC);

    // Randomized loads against the model
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      if (i % 3 == 0) v[1:0] = 2'b00;
      apply(v);
      check_model("rnd");
    end

    // Asynchronous reset mid-cycle
    apply(32'd87654321);
    chk32("pre_rst_pc", PC, 32'h0539_7FB1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk32("arst_pc", PC, 32'h0000_0000);
    chk1("arst_valid", PCValid, 1'b0);
    chk1("arst_mis", PCMisaligned, 1'b0);
    chk32("arst_plus4", PCPlus4, 32'h0000_0004);
    m_pc    = 32'h0;
    m_valid = 1'b0;

    // Edges during reset must not load
    apply(32'hDEAD_BEEF);
    check_model("inrst");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply($urandom);
      check_model("post");
    end

    // Unknowns propagate unchanged
    apply(32'hxxxx_xxxx);
    chk32("x_pc", PC, 32'hxxxx_xxxx);
    apply(32'h0000_0008);
    check_model("after_x");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_program_counter
